// File: rtl/demux_route.sv
// demux_route: buffered 1-to-N word demultiplexer with per-channel valid/ack,
// accepted-word counter and sticky bad-select flag. DEMUX_BROADCAST_EN adds in_bcast.
module demux_route #(
   parameter int WIDTH = 32,
   parameter int N_OUT = 16,
   parameter int SEL_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [N_OUT*WIDTH-1:0]   out_data,
   output logic [N_OUT-1:0]         out_valid,
   input  logic [N_OUT-1:0]         out_ack,
   output logic [15:0]              acc_cnt,
`ifdef DEMUX_BROADCAST_EN
   input  logic                     in_bcast,
`endif
   output logic                     sel_err
);

   localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

   logic [WIDTH-1:0] data_r [N_OUT];
   logic [N_OUT-1:0] valid_r;
   logic [15:0]      acc_r;
   logic             sel_err_r;

   logic [N_OUT-1:0] free_s;
   logic [N_OUT-1:0] onehot_s;
   logic [N_OUT-1:0] load_s;
   logic             sel_ok_s;
   logic             bcast_s;
   logic             ready_s;
   logic             accept_s;
   logic             bad_s;

`ifdef DEMUX_BROADCAST_EN
   assign bcast_s = in_bcast;
`else
   assign bcast_s = 1'b0;
`endif

   // Channel decode, readiness and accept/load strobes
   always_comb begin
      free_s   = ~valid_r | out_ack;
      sel_ok_s = ({1'b0, in_sel} < N_OUT_L);
      onehot_s = '0;
      for (int k = 0; k < N_OUT; k++) begin
         if (sel_ok_s && (in_sel == SEL_W'(k))) begin
            onehot_s[k] = 1'b1;
         end else begin
            onehot_s[k] = 1'b0;
         end
      end
      if (reset) begin
         ready_s = 1'b0;
      end else if (bcast_s) begin
         ready_s = &free_s;
      end else if (!sel_ok_s) begin
         ready_s = 1'b1;
      end else begin
         ready_s = |(onehot_s & free_s);
      end
      accept_s = in_valid & ready_s & (sel_ok_s | bcast_s);
      bad_s    = in_valid & ready_s & ~sel_ok_s & ~bcast_s;
      if (!accept_s) begin
         load_s = '0;
      end else if (bcast_s) begin
         load_s = '1;
      end else begin
         load_s = onehot_s;
      end
   end

   // Channel holding registers, counter and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r   <= '0;
         acc_r     <= 16'd0;
         sel_err_r <= 1'b0;
         for (int k = 0; k < N_OUT; k++) begin
            data_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (load_s[k]) begin
               data_r[k]  <= in_data;
               valid_r[k] <= 1'b1;
            end else if (out_ack[k]) begin
               valid_r[k] <= 1'b0;
            end else begin
               valid_r[k] <= valid_r[k];
            end
         end
         if (accept_s) begin
            acc_r <= acc_r + 16'd1;
         end else begin
            acc_r <= acc_r;
         end
         if (bad_s) begin
            sel_err_r <= 1'b1;
         end else begin
            sel_err_r <= sel_err_r;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_OUT; g++) begin : g_slot
         assign out_data[g*WIDTH +: WIDTH] = data_r[g];
      end
   endgenerate

   assign in_ready  = ready_s;
   assign out_valid = valid_r;
   assign acc_cnt   = acc_r;
   assign sel_err   = sel_err_r;

endmodule
